ahb_lite_interconnect: RTL

Parametrised single-master AHB-lite address decoder, slave-response multiplexer and default slave in one block. It sits between one AHB-lite master and NUM_SLV AHB-lite slaves. It generates per-slave HSEL from programmable base/mask windows and returns the selected slave's data-phase response to the master. Unmapped active transfers get a spec-compliant two-cycle ERROR response, and each error is counted and logged for debug.

---
 rtl/ahb_lite_interconnect.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ahb_lite_interconnect.sv
// Single-master AHB-lite interconnect: base/mask address decode, data-phase response mux,
// and an internal default slave that answers unmapped transfers with a two-cycle ERROR.
module ahb_lite_interconnect #(
    parameter int                        NUM_SLV  = 4,
    parameter int                        ADDR_W   = 32,
    parameter int                        DATA_W   = 32,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = '0,
    parameter int                        CNT_W    = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [ADDR_W-1:0]         HADDR,
    input  logic [1:0]                HTRANS,
    input  logic                      HWRITE,
    output logic                      HREADY,
    output logic                      HRESP,
    output logic [DATA_W-1:0]         HRDATA,
    output logic [NUM_SLV-1:0]        HSEL_S,
    input  logic [NUM_SLV-1:0]        HREADYOUT_S,
    input  logic [NUM_SLV-1:0]        HRESP_S,
    input  logic [NUM_SLV*DATA_W-1:0] HRDATA_S,
    input  logic                      err_clr,
    output logic [CNT_W-1:0]          err_count,
    output logic [ADDR_W-1:0]         err_addr,
    output logic                      err_write
);

    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    logic [NUM_SLV-1:0] match;
    logic               addr_hit;
    logic [IDX_W-1:0]   addr_idx;
    logic               trans_active;
    logic               unmapped_active;

    logic [IDX_W-1:0]   dsel_idx_q, dsel_idx_d;
    logic               dsel_dflt_q, dsel_dflt_d;
    state_t             state_q, state_d;
    logic               err_new;

    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic [ADDR_W-1:0]  err_addr_q, err_addr_d;
    logic               err_write_q, err_write_d;

    logic               slv_ready;
    logic               slv_resp;
    logic [DATA_W-1:0]  slv_rdata;
    logic               dflt_ready;
    logic               dflt_resp;

    generate
        for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_match
            assign match[gi] = ((HADDR & SLV_MASK[gi*ADDR_W +: ADDR_W]) ==
                                (SLV_BASE[gi*ADDR_W +: ADDR_W] & SLV_MASK[gi*ADDR_W +: ADDR_W]));
        end
    endgenerate

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        addr_hit = 1'b0;
        addr_idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (match[i]) begin
                addr_hit = 1'b1;
                addr_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        HSEL_S = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            HSEL_S[i] = addr_hit && (addr_idx == IDX_W'(i));
        end
    end

    assign trans_active    = (HTRANS == 2'b10) || (HTRANS == 2'b11);
    assign unmapped_active = !addr_hit && trans_active;

    always_comb begin
        dsel_idx_d  = HREADY ? addr_idx  : dsel_idx_q;
        dsel_dflt_d = HREADY ? !addr_hit : dsel_dflt_q;
    end

    always_comb begin
        slv_ready = 1'b1;
        slv_resp  = 1'b0;
        slv_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (dsel_idx_q == IDX_W'(i)) begin
                slv_ready = HREADYOUT_S[i];
                slv_resp  = HRESP_S[i];
                slv_rdata = HRDATA_S[i*DATA_W +: DATA_W];
            end
        end
    end

    // Default-slave outputs depend on state only, keeping HREADY free of a loop through err_new.
    always_comb begin
        dflt_ready = 1'b1;
        dflt_resp  = 1'b0;
        case (state_q)
            ST_ERR1: begin
                dflt_ready = 1'b0;
                dflt_resp  = 1'b1;
            end
            ST_ERR2: begin
                dflt_ready = 1'b1;
                dflt_resp  = 1'b1;
            end
            default: begin
                dflt_ready = 1'b1;
                dflt_resp  = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        err_new = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (HREADY && unmapped_active) begin
                    state_d = ST_ERR1;
                    err_new = 1'b1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                if (unmapped_active) begin
                    state_d = ST_ERR1;
                    err_new = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A fresh error outranks a simultaneous clear so the event is never lost.
    always_comb begin
        err_count_d = err_count_q;
        err_addr_d  = err_addr_q;
        err_write_d = err_write_q;
        if (err_new) begin
            if (err_clr) begin
                err_count_d = CNT_W'(1);
            end else if (!(&err_count_q)) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
            err_addr_d  = HADDR;
            err_write_d = HWRITE;
        end else if (err_clr) begin
            err_count_d = '0;
            err_addr_d  = '0;
            err_write_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            dsel_idx_q  <= '0;
            dsel_dflt_q <= 1'b1;
            err_count_q <= '0;
            err_addr_q  <= '0;
            err_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dsel_idx_q  <= dsel_idx_d;
            dsel_dflt_q <= dsel_dflt_d;
            err_count_q <= err_count_d;
            err_addr_q  <= err_addr_d;
            err_write_q <= err_write_d;
        end
    end

    assign HREADY    = dsel_dflt_q ? dflt_ready : slv_ready;
    assign HRESP     = dsel_dflt_q ? dflt_resp  : slv_resp;
    assign HRDATA    = dsel_dflt_q ? '0         : slv_rdata;
    assign err_count = err_count_q;
    assign err_addr  = err_addr_q;
    assign err_write = err_write_q;

endmodule
